// File: rtl/ctrl_pipe.sv
// Control-word pipeline: decode -> STAGES registered stages with stall/flush/kill,
// delay-slot tracking, gated write-back enable and a retire counter.
module ctrl_pipe #(
  parameter int STAGES = 3,
  parameter int CW     = 16,
  parameter int WE_BIT = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ctrl,
  input  logic                 in_next_slot,
  input  logic [STAGES-1:0]    stall,
  input  logic [STAGES-1:0]    flush,
  input  logic [STAGES-1:0]    kill,
  output logic [STAGES*CW-1:0] out_ctrl,
  output logic [STAGES-1:0]    out_valid,
  output logic [STAGES-1:0]    out_in_slot,
  output logic                 wb_we,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic                 stall_err
);

  logic [STAGES-1:0][CW-1:0] ctrl_q;
  logic [STAGES-1:0]         vld_q;
  logic [STAGES-1:0]         slot_q;
  logic                      nslot_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      err_q;

  // Word each stage i>=1 would take from stage i-1, with the kill applied.
  logic [STAGES-1:0][CW-1:0] fwd_ctrl;
  logic                      stall_bad;
  logic                      retire;

  // The last stage has nowhere to pass a killed word on to.
  logic unused_kill_last;
  assign unused_kill_last = kill[STAGES-1];

  always_comb begin
    fwd_ctrl  = '0;
    stall_bad = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      fwd_ctrl[i]         = ctrl_q[i-1];
      fwd_ctrl[i][WE_BIT] = ctrl_q[i-1][WE_BIT] & ~kill[i-1];
      stall_bad           = stall_bad | (stall[i] & ~stall[i-1]);
    end
  end

  assign retire = vld_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q  <= '0;
      vld_q   <= '0;
      slot_q  <= '0;
      nslot_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (flush[0]) begin
        ctrl_q[0] <= '0;
        vld_q[0]  <= 1'b0;
        slot_q[0] <= 1'b0;
        nslot_q   <= 1'b0;
      end else if (!stall[0]) begin
        ctrl_q[0] <= in_ctrl;
        vld_q[0]  <= in_valid;
        slot_q[0] <= nslot_q;
        nslot_q   <= in_next_slot;
      end

      for (int i = 1; i < STAGES; i++) begin
        if (flush[i] || (!stall[i] && stall[i-1])) begin
          // Flush, or bubble inserted below a stalled upstream stage.
          ctrl_q[i] <= '0;
          vld_q[i]  <= 1'b0;
          slot_q[i] <= 1'b0;
        end else if (!stall[i]) begin
          ctrl_q[i] <= fwd_ctrl[i];
          vld_q[i]  <= vld_q[i-1];
          slot_q[i] <= slot_q[i-1];
        end
      end

      if (retire) cnt_q <= cnt_q + CNT_W'(1);
      if (stall_bad) err_q <= 1'b1;
    end
  end

  assign out_ctrl    = ctrl_q;
  assign out_valid   = vld_q;
  assign out_in_slot = slot_q;
  assign wb_we       = ctrl_q[STAGES-1][WE_BIT] & vld_q[STAGES-1] & ~stall[STAGES-2];
  assign retire_cnt  = cnt_q;
  assign stall_err   = err_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios then random traffic, all against a queue-free stage model.
module tb_ctrl_pipe;
  localparam int S   = 3;
  localparam int CW  = 16;
  localparam int WE  = 4;
  localparam int CNW = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic [CW-1:0]   in_ctrl;
  logic            in_next_slot;
  logic [S-1:0]    stall, flush, kill;
  logic [S*CW-1:0] out_ctrl;
  logic [S-1:0]    out_valid, out_in_slot;
  logic            wb_we;
  logic [CNW-1:0]  retire_cnt;
  logic            stall_err;

  int checks = 0;
  int errors = 0;

  // Reference state: one entry per stage.
  logic [CW-1:0] m_ctrl [S];
  logic          m_vld  [S];
  logic          m_slot [S];
  logic          m_nslot;
  int            m_cnt;
  logic          m_err;

  always #5 clk = ~clk;

  ctrl_pipe #(.STAGES(S), .CW(CW), .WE_BIT(WE), .CNT_W(CNW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_next_slot(in_next_slot), .stall(stall), .flush(flush), .kill(kill),
    .out_ctrl(out_ctrl), .out_valid(out_valid), .out_in_slot(out_in_slot),
    .wb_we(wb_we), .retire_cnt(retire_cnt), .stall_err(stall_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [CW-1:0] we_mask;
    we_mask = '0;
    we_mask[WE] = 1'b1;
    if (!resetn) begin
      for (int i = 0; i < S; i++) begin
        m_ctrl[i] = '0; m_vld[i] = 1'b0; m_slot[i] = 1'b0;
      end
      m_nslot = 1'b0; m_cnt = 0; m_err = 1'b0;
      return;
    end
    if (m_vld[S-1] && !stall[S-1] && !flush[S-1]) m_cnt = (m_cnt + 1) % (1 << CNW);
    for (int i = 1; i < S; i++)
      if (stall[i] && !stall[i-1]) m_err = 1'b1;
    // Walk from the tail so every stage still sees its predecessor's old word.
    for (int i = S - 1; i >= 1; i--) begin
      if (flush[i]) begin
        m_ctrl[i] = '0; m_vld[i] = 1'b0; m_slot[i] = 1'b0;
      end else if (stall[i]) begin
        // held
      end else if (stall[i-1]) begin
        m_ctrl[i] = '0; m_vld[i] = 1'b0; m_slot[i] = 1'b0;
      end else begin
        m_ctrl[i] = kill[i-1] ? (m_ctrl[i-1] & ~we_mask) : m_ctrl[i-1];
        m_vld[i]  = m_vld[i-1];
        m_slot[i] = m_slot[i-1];
      end
    end
    if (flush[0]) begin
      m_ctrl[0] = '0; m_vld[0] = 1'b0; m_slot[0] = 1'b0; m_nslot = 1'b0;
    end else if (!stall[0]) begin
      m_slot[0] = m_nslot;
      m_nslot   = in_next_slot;
      m_ctrl[0] = in_ctrl;
      m_vld[0]  = in_valid;
    end
  endtask

  task automatic check_model();
    logic [S*CW-1:0] ec;
    logic [S-1:0]    ev, es;
    for (int i = 0; i < S; i++) begin
      ec[i*CW +: CW] = m_ctrl[i];
      ev[i] = m_vld[i];
      es[i] = m_slot[i];
    end
    chk("out_ctrl", 64'(out_ctrl), 64'(ec));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_in_slot", 64'(out_in_slot), 64'(es));
    chk("wb_we", 64'(wb_we), 64'(m_ctrl[S-1][WE] & m_vld[S-1] & ~stall[S-2]));
    chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    chk("stall_err", 64'(stall_err), 64'(m_err));
  endtask

  // Apply current inputs for one edge, then compare against the model.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_ctrl = '0; in_next_slot = 1'b0;
    stall = '0; flush = '0; kill = '0;
  endtask

  int base;
  logic [CW-1:0] words [5];

  initial begin
    resetn = 1'b0;
    idle();
    #1;

    // Reset / idle
    step(); step();
    chk("rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(retire_cnt), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);

    // First word reaches the last stage after 3 edges
    resetn = 1'b1;
    in_valid = 1'b1; in_ctrl = 16'h0010;
    step();
    idle();
    step(); step();
    chk("first_s2_ctrl", 64'(out_ctrl[2*CW +: CW]), 64'h0010);
    chk("first_s2_valid", 64'(out_valid[2]), 64'd1);
    chk("first_wb_we", 64'(wb_we), 64'd1);
    step();
    chk("first_retire", 64'(retire_cnt), 64'd1);

    // Stream of 5 back-to-back words
    base = m_cnt;
    for (int k = 0; k < 5; k++) words[k] = CW'($urandom);
    for (int e = 1; e <= 8; e++) begin
      idle();
      if (e <= 5) begin
        in_valid = 1'b1; in_ctrl = words[e-1];
      end
      step();
      if (e >= 3 && e <= 7) chk("stream_order", 64'(out_ctrl[2*CW +: CW]), 64'(words[e-3]));
    end
    chk("stream_cnt", 64'(retire_cnt), 64'((base + 5) % 16));

    // Stall stage 0 for two cycles: bubbles below it
    idle(); in_valid = 1'b1; in_ctrl = 16'h1234;
    step();
    idle(); stall = 3'b001; in_valid = 1'b1; in_ctrl = 16'hBEEF;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("stall_s0_hold", 64'(out_ctrl[CW-1:0]), 64'h1234);
      chk("stall_s1_bubble", 64'(out_valid[1]), 64'd0);
    end
    idle();
    for (int c = 0; c < 4; c++) step();

    // Kill clears only the write-enable
    idle(); in_valid = 1'b1; in_ctrl = 16'h0010;
    step();
    idle(); kill = 3'b001;
    base = m_cnt;
    step();
    chk("kill_s1_ctrl", 64'(out_ctrl[CW +: CW]), 64'h0000);
    chk("kill_s1_valid", 64'(out_valid[1]), 64'd1);
    idle();
    step();
    chk("kill_wb_we", 64'(wb_we), 64'd0);
    step();
    chk("kill_cnt", 64'(retire_cnt), 64'((base + 1) % 16));

    // Delay slot tracking, then flushed away
    idle(); in_valid = 1'b1; in_ctrl = 16'h00A0; in_next_slot = 1'b1;
    step();
    in_ctrl = 16'h00B0; in_next_slot = 1'b0;
    step();
    chk("slot_B", 64'(out_in_slot[0]), 64'd1);
    in_ctrl = 16'h00A0; in_next_slot = 1'b1;
    step();
    idle(); flush = 3'b001;
    step();
    idle(); in_valid = 1'b1; in_ctrl = 16'h00B0;
    step();
    chk("slot_B_flushed", 64'(out_in_slot[0]), 64'd0);

    // Illegal stall pattern is sticky
    idle(); stall = 3'b010;
    step();
    chk("stall_err_set", 64'(stall_err), 64'd1);
    idle();
    step(); step();
    chk("stall_err_sticky", 64'(stall_err), 64'd1);

    // Counter wrap: 17 retires on a 4-bit counter
    resetn = 1'b0; idle();
    step();
    resetn = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_ctrl = CW'($urandom);
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) step();
    chk("wrap_cnt", 64'(retire_cnt), 64'd1);

    // Random traffic, including occasional mid-stream reset
    for (int c = 0; c < 400; c++) begin
      resetn       = ($urandom_range(0, 31) != 0);
      in_valid     = 1'($urandom);
      in_ctrl      = CW'($urandom);
      in_next_slot = 1'($urandom);
      stall        = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      flush        = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
      kill         = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
